change_dispenser: RTL and testbench

Change-payout stage directly downstream of the vending FSM. It accepts a change amount in rupees and pays it out coin by coin to a coin ejector using a valid/ack handshake. Denominations are chosen greedily from per-denomination hopper inventories. Any amount that cannot be paid is reported as owed.

---
 rtl/vending_pkg.sv | 49 ++++
 rtl/coin_hopper_bank.sv | 67 ++++++
 rtl/change_dispenser.sv | 140 ++++++++++++++
 tb/tb_change_dispenser.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vending_pkg
// Purpose  : Shared definitions for the change-payout path: denomination
//            codes, their rupee values, and the payout FSM state encoding.
// Contents : NUM_DENOM, COIN_* codes, coin_value(), state_e
// Revision : 1.0 - initial release
// ============================================================================
package vending_pkg;

  localparam int NUM_DENOM = 5;

  // Denomination codes, ordered from largest to smallest value so that the
  // lowest code is always the greedy first choice.
  localparam logic [2:0] COIN_20 = 3'd0;
  localparam logic [2:0] COIN_10 = 3'd1;
  localparam logic [2:0] COIN_5  = 3'd2;
  localparam logic [2:0] COIN_2  = 3'd3;
  localparam logic [2:0] COIN_1  = 3'd4;

  localparam logic [7:0] VAL_20 = 8'd20;
  localparam logic [7:0] VAL_10 = 8'd10;
  localparam logic [7:0] VAL_5  = 8'd5;
  localparam logic [7:0] VAL_2  = 8'd2;
  localparam logic [7:0] VAL_1  = 8'd1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Rupee value of a denomination code; unused codes are worth nothing.
  function automatic logic [7:0] coin_value(input logic [2:0] code);
    logic [7:0] v;
    case (code)
      COIN_20: v = VAL_20;
      COIN_10: v = VAL_10;
      COIN_5:  v = VAL_5;
      COIN_2:  v = VAL_2;
      COIN_1:  v = VAL_1;
      default: v = 8'd0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coin_hopper_bank.sv
`default_nettype none
// ============================================================================
// Module   : coin_hopper_bank
// Purpose  : Five hopper inventory counters. Each counter decrements when a
//            coin of its denomination is acknowledged and adds refill coins
//            with saturation at 2^INV_W-1.
// Ports    : clk, rst_n          clock, async active-low reset
//            i_dec_en/i_dec_sel  decrement one hopper (coin taken)
//            i_refill/_sel/_cnt  add coins to one hopper (codes 5-7 ignored)
//            o_nonzero           per-hopper count != 0
//            o_empty             per-hopper count == 0 (registered)
// Revision : 1.0 - initial release
// ============================================================================
module coin_hopper_bank
  import vending_pkg::*;
#(
  parameter int INV_W    = 6,
  parameter int INV_INIT = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_dec_en,
  input  logic [2:0]           i_dec_sel,
  input  logic                 i_refill,
  input  logic [2:0]           i_refill_sel,
  input  logic [INV_W-1:0]     i_refill_cnt,
  output logic [NUM_DENOM-1:0] o_nonzero,
  output logic [NUM_DENOM-1:0] o_empty
);

  localparam logic [INV_W:0]   c_max  = {1'b0, {INV_W{1'b1}}};
  localparam logic [INV_W-1:0] c_init = INV_W'(INV_INIT);

  for (genvar k = 0; k < NUM_DENOM; k++) begin : g_hopper
    logic [INV_W-1:0] r_count;
    logic             r_empty;
    logic             w_dec;
    logic             w_add;
    logic [INV_W:0]   w_sum;
    logic [INV_W-1:0] w_next;

    assign w_dec = i_dec_en && (i_dec_sel == 3'(k)) && (r_count != '0);
    assign w_add = i_refill && (i_refill_sel == 3'(k));

    // One extra bit of headroom: count-1+refill never exceeds 2*(2^INV_W-1),
    // and count>=1 whenever w_dec is set, so no underflow.
    assign w_sum  = {1'b0, r_count} - (INV_W+1)'(w_dec)
                  + (w_add ? {1'b0, i_refill_cnt} : '0);
    assign w_next = (w_sum > c_max) ? c_max[INV_W-1:0] : w_sum[INV_W-1:0];

    // Empty flag is computed from the next count so it never lags the counter.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_count <= c_init;
        r_empty <= (c_init == '0);
      end else begin
        r_count <= w_next;
        r_empty <= (w_next == '0);
      end
    end

    assign o_empty[k]   = r_empty;
    assign o_nonzero[k] = ~r_empty;
  end

endmodule
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Pays out a change amount coin by coin, choosing denominations
//            greedily from the hopper inventories; reports any unpayable
//            remainder as owed.
// Ports    : clk, reset (async, active-low)
//            change_in/change_req    payout request (accepted when !busy)
//            busy, done, shortfall   status; done is a one-cycle pulse
//            coin_valid/coin_sel/coin_ack  coin ejector handshake
//            refill/refill_sel/refill_cnt  hopper refill strobe
//            owed                    unpaid remainder of the last payout
//            hopper_empty            per-hopper empty flags
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser
  import vending_pkg::*;
#(
  parameter int INV_W    = 6,
  parameter int INV_INIT = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           change_in,
  input  logic                 change_req,
  output logic                 busy,
  output logic                 coin_valid,
  output logic [2:0]           coin_sel,
  input  logic                 coin_ack,
  input  logic                 refill,
  input  logic [2:0]           refill_sel,
  input  logic [INV_W-1:0]     refill_cnt,
  output logic                 done,
  output logic                 shortfall,
  output logic [7:0]           owed,
  output logic [NUM_DENOM-1:0] hopper_empty
);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [7:0]             r_remaining;
  logic [7:0]             r_owed;
  logic [2:0]             r_sel;
  logic [NUM_DENOM-1:0]   w_nonzero;
  logic                   w_found;
  logic [2:0]             w_pick;
  logic                   w_ack;

  assign w_ack = (r_state == ST_ISSUE) && coin_ack;

  coin_hopper_bank #(
    .INV_W    (INV_W),
    .INV_INIT (INV_INIT)
  ) u_bank (
    .clk          (clk),
    .rst_n        (reset),
    .i_dec_en     (w_ack),
    .i_dec_sel    (r_sel),
    .i_refill     (refill),
    .i_refill_sel (refill_sel),
    .i_refill_cnt (refill_cnt),
    .o_nonzero    (w_nonzero),
    .o_empty      (hopper_empty)
  );

  // Greedy selector: scan smallest to largest so the last hit is the largest
  // affordable denomination that still has stock.
  always_comb begin
    w_found = 1'b0;
    w_pick  = COIN_20;
    for (int k = NUM_DENOM - 1; k >= 0; k--) begin
      if (w_nonzero[k] && (coin_value(3'(k)) <= r_remaining)) begin
        w_found = 1'b1;
        w_pick  = 3'(k);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (change_req) w_state_next = ST_SELECT;
      ST_SELECT: w_state_next = w_found ? ST_ISSUE : ST_FINISH;
      ST_ISSUE:  if (coin_ack) w_state_next = ST_SELECT;
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Outputs decode directly from the state register, so an async reset
  // clears them without waiting for a clock.
  always_comb begin
    busy       = (r_state != ST_IDLE);
    coin_valid = (r_state == ST_ISSUE);
    done       = (r_state == ST_FINISH);
    shortfall  = (r_state == ST_FINISH) && (r_remaining != 8'd0);
    coin_sel   = r_sel;
    owed       = r_owed;
  end

  // Payout datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_remaining <= 8'd0;
      r_owed      <= 8'd0;
      r_sel       <= COIN_20;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (change_req) begin
            r_remaining <= change_in;
            r_owed      <= 8'd0;
          end
        end
        ST_SELECT: begin
          if (w_found) r_sel <= w_pick;
        end
        ST_ISSUE: begin
          if (coin_ack) r_remaining <= r_remaining - coin_value(r_sel);
        end
        ST_FINISH: begin
          r_owed <= r_remaining;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser
// Purpose  : Directed self-checking bench for change_dispenser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] change_in;
  logic       change_req;
  logic       busy;
  logic       coin_valid;
  logic [2:0] coin_sel;
  logic       coin_ack;
  logic       refill;
  logic [2:0] refill_sel;
  logic [5:0] refill_cnt;
  logic       done;
  logic       shortfall;
  logic [7:0] owed;
  logic [4:0] hopper_empty;

  change_dispenser #(.INV_W(6), .INV_INIT(20)) dut (
    .clk          (clk),
    .reset        (reset),
    .change_in    (change_in),
    .change_req   (change_req),
    .busy         (busy),
    .coin_valid   (coin_valid),
    .coin_sel     (coin_sel),
    .coin_ack     (coin_ack),
    .refill       (refill),
    .refill_sel   (refill_sel),
    .refill_cnt   (refill_cnt),
    .done         (done),
    .shortfall    (shortfall),
    .owed         (owed),
    .hopper_empty (hopper_empty)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [2:0] coins[$];
  int         cyc;
  int         first_lat;
  int         done_lat;
  logic       got_done;
  logic       got_short;
  logic       busy_at_done;
  logic       busy_after;
  logic [7:0] owed_after;

  function automatic int val(input logic [2:0] c);
    case (c)
      3'd0: return 20;
      3'd1: return 10;
      3'd2: return 5;
      3'd3: return 2;
      3'd4: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int coin_sum();
    int s = 0;
    foreach (coins[i]) s += val(coins[i]);
    return s;
  endfunction

  // All tasks start and end at a falling edge.
  task automatic start_req(input logic [7:0] amt);
    change_in  = amt;
    change_req = 1'b1;
    @(negedge clk);
    change_req = 1'b0;
    cyc        = 1;
    first_lat  = -1;
    coins.delete();
  endtask

  // Acks every offered coin on the cycle after it appears, until done.
  task automatic collect();
    got_done = 1'b0;
    for (int i = 0; i < 3000 && !got_done; i++) begin
      if (done) begin
        got_done     = 1'b1;
        done_lat     = cyc;
        got_short    = shortfall;
        busy_at_done = busy;
        @(negedge clk);
        cyc++;
        busy_after = busy;
        owed_after = owed;
      end else begin
        if (coin_valid) begin
          if (first_lat < 0) first_lat = cyc;
          coins.push_back(coin_sel);
          coin_ack = 1'b1;
        end
        @(negedge clk);
        coin_ack = 1'b0;
        cyc++;
      end
    end
  endtask

  task automatic pay(input logic [7:0] amt);
    start_req(amt);
    collect();
  endtask

  task automatic do_refill(input logic [2:0] sel, input logic [5:0] cnt);
    refill     = 1'b1;
    refill_sel = sel;
    refill_cnt = cnt;
    @(negedge clk);
    refill     = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (coin_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", coin_valid); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (shortfall !== 1'b0) $display("FAIL reset_short: got %b want 0", shortfall); else n_pass++;
    n_total++; if (owed !== 8'd0) $display("FAIL reset_owed: got %0d want 0", owed); else n_pass++;
    n_total++; if (coin_sel !== 3'd0) $display("FAIL reset_sel: got %0d want 0", coin_sel); else n_pass++;
    n_total++; if (hopper_empty !== 5'b0) $display("FAIL reset_empty: got %b want 00000", hopper_empty); else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_pay45();
    pay(8'd45);
    n_total++; if (got_done !== 1'b1) $display("FAIL p45_done: got %b want 1", got_done); else n_pass++;
    n_total++; if (coins.size() !== 3) $display("FAIL p45_ncoins: got %0d want 3", coins.size()); else n_pass++;
    if (coins.size() == 3) begin
      n_total++; if (coins[0] !== 3'd0) $display("FAIL p45_c0: got %0d want 0", coins[0]); else n_pass++;
      n_total++; if (coins[1] !== 3'd0) $display("FAIL p45_c1: got %0d want 0", coins[1]); else n_pass++;
      n_total++; if (coins[2] !== 3'd2) $display("FAIL p45_c2: got %0d want 2", coins[2]); else n_pass++;
    end
    n_total++; if (first_lat !== 2) $display("FAIL p45_first_lat: got %0d want 2", first_lat); else n_pass++;
    n_total++; if (done_lat !== 8) $display("FAIL p45_done_lat: got %0d want 8", done_lat); else n_pass++;
    n_total++; if (got_short !== 1'b0) $display("FAIL p45_short: got %b want 0", got_short); else n_pass++;
    n_total++; if (owed_after !== 8'd0) $display("FAIL p45_owed: got %0d want 0", owed_after); else n_pass++;
    n_total++; if (busy_at_done !== 1'b1) $display("FAIL p45_busy_done: got %b want 1", busy_at_done); else n_pass++;
    n_total++; if (busy_after !== 1'b0) $display("FAIL p45_busy_after: got %b want 0", busy_after); else n_pass++;
    n_total++; if (dut.u_bank.g_hopper[0].r_count !== 6'd18)
      $display("FAIL p45_cnt20: got %0d want 18", dut.u_bank.g_hopper[0].r_count); else n_pass++;
  endtask

  // Issued immediately after the previous done: also exercises back-to-back.
  task automatic test_zero();
    pay(8'd0);
    n_total++; if (got_done !== 1'b1) $display("FAIL z_done: got %b want 1", got_done); else n_pass++;
    n_total++; if (coins.size() !== 0) $display("FAIL z_ncoins: got %0d want 0", coins.size()); else n_pass++;
    n_total++; if (done_lat !== 2) $display("FAIL z_done_lat: got %0d want 2", done_lat); else n_pass++;
    n_total++; if (got_short !== 1'b0) $display("FAIL z_short: got %b want 0", got_short); else n_pass++;
  endtask

  task automatic test_stall();
    logic [2:0] sel0;
    start_req(8'd7);
    for (int i = 0; i < 10 && !coin_valid; i++) begin
      @(negedge clk);
      cyc++;
    end
    n_total++; if (coin_valid !== 1'b1) $display("FAIL st_valid_wait: got %b want 1", coin_valid); else n_pass++;
    sel0 = coin_sel;
    n_total++; if (sel0 !== 3'd2) $display("FAIL st_sel0: got %0d want 2", sel0); else n_pass++;
    for (int j = 0; j < 5; j++) begin
      change_in  = 8'd200;
      change_req = (j == 1);
      @(negedge clk);
      cyc++;
      n_total++; if (coin_valid !== 1'b1) $display("FAIL st_hold_valid%0d: got %b want 1", j, coin_valid); else n_pass++;
      n_total++; if (coin_sel !== sel0) $display("FAIL st_hold_sel%0d: got %0d want %0d", j, coin_sel, sel0); else n_pass++;
    end
    change_req = 1'b0;
    coins.push_back(sel0);
    coin_ack = 1'b1;
    @(negedge clk);
    coin_ack = 1'b0;
    cyc++;
    collect();
    n_total++; if (coins.size() !== 2) $display("FAIL st_ncoins: got %0d want 2", coins.size()); else n_pass++;
    if (coins.size() == 2) begin
      n_total++; if (coins[1] !== 3'd3) $display("FAIL st_c1: got %0d want 3", coins[1]); else n_pass++;
    end
    n_total++; if (owed_after !== 8'd0) $display("FAIL st_owed: got %0d want 0", owed_after); else n_pass++;
    // A queued 200 request would have started a payout right away.
    @(negedge clk);
    n_total++; if (busy !== 1'b0) $display("FAIL st_no_queue: got %b want 0", busy); else n_pass++;
  endtask

  // Inventory here: 20:18 10:20 5:18 2:19 1:20
  task automatic test_empty20();
    pay(8'd255);   // 12x20, 10, 5
    n_total++; if (coins.size() !== 14) $display("FAIL e_255_n: got %0d want 14", coins.size()); else n_pass++;
    n_total++; if (coin_sum() !== 255) $display("FAIL e_255_sum: got %0d want 255", coin_sum()); else n_pass++;
    pay(8'd120);   // last 6x20
    n_total++; if (coins.size() !== 6) $display("FAIL e_120_n: got %0d want 6", coins.size()); else n_pass++;
    n_total++; if (hopper_empty !== 5'b00001) $display("FAIL e_empty20: got %b want 00001", hopper_empty); else n_pass++;
    pay(8'd30);
    n_total++; if (coins.size() !== 3) $display("FAIL e_30_n: got %0d want 3", coins.size()); else n_pass++;
    foreach (coins[i]) begin
      n_total++; if (coins[i] !== 3'd1) $display("FAIL e_30_c%0d: got %0d want 1", i, coins[i]); else n_pass++;
    end
    n_total++; if (got_short !== 1'b0) $display("FAIL e_30_short: got %b want 0", got_short); else n_pass++;
  endtask

  // Inventory here: 20:0 10:16 5:17 2:19 1:20
  task automatic test_shortfall();
    pay(8'd255);   // 16x10, 17x5, 5x2
    n_total++; if (coins.size() !== 38) $display("FAIL s_255_n: got %0d want 38", coins.size()); else n_pass++;
    n_total++; if (coin_sum() !== 255) $display("FAIL s_255_sum: got %0d want 255", coin_sum()); else n_pass++;
    pay(8'd28);    // 14x2
    n_total++; if (hopper_empty !== 5'b01111) $display("FAIL s_empty_a: got %b want 01111", hopper_empty); else n_pass++;
    pay(8'd19);    // 19x1, one left
    n_total++; if (coins.size() !== 19) $display("FAIL s_19_n: got %0d want 19", coins.size()); else n_pass++;
    pay(8'd3);
    n_total++; if (coins.size() !== 1) $display("FAIL s_3_n: got %0d want 1", coins.size()); else n_pass++;
    if (coins.size() == 1) begin
      n_total++; if (coins[0] !== 3'd4) $display("FAIL s_3_c0: got %0d want 4", coins[0]); else n_pass++;
    end
    n_total++; if (got_short !== 1'b1) $display("FAIL s_3_short: got %b want 1", got_short); else n_pass++;
    n_total++; if (owed_after !== 8'd2) $display("FAIL s_3_owed: got %0d want 2", owed_after); else n_pass++;
    n_total++; if (hopper_empty !== 5'b11111) $display("FAIL s_empty_all: got %b want 11111", hopper_empty); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_refill(3'd5, 6'd9);   // unused code: no hopper changes
    n_total++; if (hopper_empty !== 5'b11111) $display("FAIL r_refill_bad: got %b want 11111", hopper_empty); else n_pass++;
    do_refill(3'd0, 6'd5);
    n_total++; if (hopper_empty !== 5'b11110) $display("FAIL r_refill20: got %b want 11110", hopper_empty); else n_pass++;
    start_req(8'd40);
    for (int i = 0; i < 10 && !coin_valid; i++) @(negedge clk);
    n_total++; if (coin_valid !== 1'b1) $display("FAIL r_issue: got %b want 1", coin_valid); else n_pass++;
    #1 reset = 1'b0;
    #1;
    n_total++; if (coin_valid !== 1'b0) $display("FAIL r_async_valid: got %b want 0", coin_valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL r_async_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (owed !== 8'd0) $display("FAIL r_async_owed: got %0d want 0", owed); else n_pass++;
    n_total++; if (hopper_empty !== 5'b0) $display("FAIL r_async_empty: got %b want 00000", hopper_empty); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pay(8'd25);
    n_total++; if (coins.size() !== 2) $display("FAIL r_25_n: got %0d want 2", coins.size()); else n_pass++;
    if (coins.size() == 2) begin
      n_total++; if (coins[0] !== 3'd0) $display("FAIL r_25_c0: got %0d want 0", coins[0]); else n_pass++;
      n_total++; if (coins[1] !== 3'd2) $display("FAIL r_25_c1: got %0d want 2", coins[1]); else n_pass++;
    end
    n_total++; if (owed_after !== 8'd0) $display("FAIL r_25_owed: got %0d want 0", owed_after); else n_pass++;
    n_total++; if (dut.u_bank.g_hopper[0].r_count !== 6'd19)
      $display("FAIL r_cnt20: got %0d want 19", dut.u_bank.g_hopper[0].r_count); else n_pass++;
    do_refill(3'd0, 6'd63);
    n_total++; if (dut.u_bank.g_hopper[0].r_count !== 6'd63)
      $display("FAIL r_sat: got %0d want 63", dut.u_bank.g_hopper[0].r_count); else n_pass++;
    n_total++; if (hopper_empty !== 5'b0) $display("FAIL r_sat_empty: got %b want 00000", hopper_empty); else n_pass++;
  endtask

  initial begin
    reset      = 1'b0;
    change_in  = 8'd0;
    change_req = 1'b0;
    coin_ack   = 1'b0;
    refill     = 1'b0;
    refill_sel = 3'd0;
    refill_cnt = 6'd0;
    test_reset();
    test_pay45();
    test_zero();
    test_stall();
    test_empty20();
    test_shortfall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
